// File: rtl/dht11_disp_pkg.sv
// Shared encodings, segment table and BCD helper for the DHT11 7-segment display path.
package dht11_disp_pkg;

  localparam logic MODE_TEMP = 1'b0;
  localparam logic MODE_HUMI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // gfedcba, active-low; entry 0 is the rightmost element
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [7:0]  SEG_BLANK      = 8'hFF;
  localparam logic [13:0] MAX_DISP       = 14'd9999;
  localparam logic [1:0]  DP_DIGIT       = 2'd2;
  localparam logic [3:0]  BCD_LAST_SHIFT = 4'd13;

  function automatic logic [7:0] digit_seg(input logic [3:0] d, input logic dp_on);
    logic [6:0] code;
    if (d <= 4'd9) code = SEG_LUT[d];
    else           code = 7'h7F;
    return {~dp_on, code};
  endfunction

  function automatic logic [15:0] bcd_adjust(input logic [15:0] s);
    logic [15:0] r;
    for (int n = 0; n < 4; n++) begin
      if (s[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = s[n*4 +: 4] + 4'd3;
      else                     r[n*4 +: 4] = s[n*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: 14-bit binary to 4 BCD digits in LOAD + 14 SHIFT + DONE cycles.
module bin2bcd_iter
  import dht11_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_e state_q, state_d;
  logic [3:0]  cnt_q;
  logic [13:0] bin_q;
  logic [15:0] scratch_q;
  logic [15:0] adj;
  logic        busy_q;
  logic [15:0] bcd_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == BCD_LAST_SHIFT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign adj = bcd_adjust(scratch_q);

  // bcd_q only changes in DONE, so an aborted conversion never leaks a partial result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      bin_q     <= 14'd0;
      scratch_q <= 16'd0;
      busy_q    <= 1'b0;
      bcd_q     <= 16'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          bin_q     <= bin;
          scratch_q <= 16'd0;
          cnt_q     <= 4'd0;
          busy_q    <= 1'b1;
        end
        ST_SHIFT: begin
          scratch_q <= {adj[14:0], bin_q[13]};
          bin_q     <= {bin_q[12:0], 1'b0};
          cnt_q     <= cnt_q + 4'd1;
        end
        ST_DONE: begin
          bcd_q  <= scratch_q;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/dht11_fnd_display.sv
// Shows DHT11 temperature (XX.YY) or humidity on a 4-digit common-anode display,
// alternating automatically or by manual selection.
module dht11_fnd_display
  import dht11_disp_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1_000,
  parameter int unsigned TOGGLE_TICKS = 2_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] humidity,
  input  logic [13:0] temperature,
  input  logic        auto_en,
  input  logic        mode_sel,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        conv_busy
);

  localparam int unsigned TICK_DIV = CLOCK_FREQ / SCAN_HZ;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TOG_W    = (TOGGLE_TICKS > 1) ? $clog2(TOGGLE_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(TOGGLE_TICKS - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TOG_W-1:0]  toggle_cnt_q, toggle_cnt_d;
  logic              mode_q, mode_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [13:0]       last_src_q, last_src_d;
  logic              last_mode_q, last_mode_d;
  logic              disp_mode_q, disp_mode_d;
  logic              valid_q, valid_d;
  logic              conv_pend_q, conv_pend_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;

  logic        scan_tick;
  logic [13:0] src_raw, src_clamped;
  logic        conv_start, conv_done;
  logic [15:0] bcd_reg;
  logic [3:0]  digit;
  logic        lead_blank;

  bin2bcd_iter u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (last_src_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd_reg)
  );

  // Scan divider and mode selection
  always_comb begin
    tick_cnt_d   = tick_cnt_q + TICK_W'(1);
    scan_tick    = 1'b0;
    toggle_cnt_d = toggle_cnt_q;
    mode_d       = mode_q;
    digit_idx_d  = digit_idx_q;
    if (tick_cnt_q == TICK_LAST) begin
      scan_tick  = 1'b1;
      tick_cnt_d = '0;
    end else begin
      scan_tick  = 1'b0;
    end
    if (scan_tick) digit_idx_d = digit_idx_q + 2'd1;
    else           digit_idx_d = digit_idx_q;
    if (auto_en) begin
      if (scan_tick && toggle_cnt_q == TOG_LAST) begin
        toggle_cnt_d = '0;
        mode_d       = ~mode_q;
      end else if (scan_tick) begin
        toggle_cnt_d = toggle_cnt_q + TOG_W'(1);
      end else begin
        toggle_cnt_d = toggle_cnt_q;
      end
    end else begin
      toggle_cnt_d = '0;
      mode_d       = mode_sel;
    end
  end

  // Change detection: a new conversion is requested only while none is outstanding
  always_comb begin
    src_raw     = (mode_q == MODE_HUMI) ? humidity : temperature;
    src_clamped = (src_raw > MAX_DISP) ? MAX_DISP : src_raw;
    conv_start  = ~conv_pend_q &
                  (~valid_q | (src_clamped != last_src_q) | (mode_q != last_mode_q));
    last_src_d  = last_src_q;
    last_mode_d = last_mode_q;
    disp_mode_d = disp_mode_q;
    valid_d     = valid_q;
    conv_pend_d = conv_pend_q;
    if (conv_start) begin
      last_src_d  = src_clamped;
      last_mode_d = mode_q;
      conv_pend_d = 1'b1;
    end else if (conv_done) begin
      conv_pend_d = 1'b0;
      valid_d     = 1'b1;
      disp_mode_d = last_mode_q;
    end else begin
      conv_pend_d = conv_pend_q;
    end
  end

  // Digit formatting for the currently scanned position
  always_comb begin
    digit = bcd_reg[{digit_idx_q, 2'b00} +: 4];
    case (digit_idx_q)
      2'd3:    lead_blank = (bcd_reg[15:12] == 4'd0);
      2'd2:    lead_blank = (bcd_reg[15:8] == 8'd0);
      2'd1:    lead_blank = (bcd_reg[15:4] == 12'd0);
      default: lead_blank = 1'b0;
    endcase
    if (disp_mode_q == MODE_HUMI) begin
      seg_d = lead_blank ? SEG_BLANK : digit_seg(digit, 1'b0);
    end else begin
      seg_d = digit_seg(digit, digit_idx_q == DP_DIGIT);
    end
    an_d = ~(4'b0001 << digit_idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      toggle_cnt_q <= '0;
      mode_q       <= MODE_TEMP;
      digit_idx_q  <= 2'd0;
      last_src_q   <= 14'd0;
      last_mode_q  <= MODE_TEMP;
      disp_mode_q  <= MODE_TEMP;
      valid_q      <= 1'b0;
      conv_pend_q  <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      mode_q       <= mode_d;
      digit_idx_q  <= digit_idx_d;
      last_src_q   <= last_src_d;
      last_mode_q  <= last_mode_d;
      disp_mode_q  <= disp_mode_d;
      valid_q      <= valid_d;
      conv_pend_q  <= conv_pend_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_dht11_fnd_display.sv
// Randomized and directed checks of dht11_fnd_display against a decimal reference model.
module tb_dht11_fnd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] humidity, temperature;
  logic        auto_en, mode_sel;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        conv_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [6:0] seg7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  dht11_fnd_display #(
    .CLOCK_FREQ  (100),
    .SCAN_HZ     (10),
    .TOGGLE_TICKS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .humidity   (humidity),
    .temperature(temperature),
    .auto_en    (auto_en),
    .mode_sel   (mode_sel),
    .seg        (seg),
    .an         (an),
    .conv_busy  (conv_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  // Expected segment byte for decimal position i of value v in the given mode
  function automatic logic [7:0] exp_seg(input int v, input bit m, input int i);
    int pw;
    int dg;
    pw = 1;
    for (int k = 0; k < i; k++) pw = pw * 10;
    dg = (v / pw) % 10;
    if (m && i > 0 && v < pw) return 8'hFF;
    return {(!m && i == 2) ? 1'b0 : 1'b1, seg7[dg]};
  endfunction

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic wait_busy(input logic lvl, input int max, input string tag, output int n);
    n = 0;
    while (conv_busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (conv_busy !== lvl) begin
      check_eq({tag, "_timeout"}, {31'd0, conv_busy}, {31'd0, lvl});
      n = -1;
    end
  endtask

  // Walk all four scan positions, one digit period apart
  task automatic check_display(input string tag, input int raw, input bit m);
    int v;
    int i0;
    int idx;
    v = clamp(raw);
    check_eq({tag, "_idle"}, {31'd0, conv_busy}, 32'd0);
    i0 = an_index(an);
    if (i0 < 0) begin
      check_eq({tag, "_an"}, {28'd0, an}, 32'hE);
      i0 = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (10) @(negedge clk);
      idx = (i0 + k) % 4;
      if (k > 0) check_eq({tag, "_an"}, {28'd0, an}, {28'd0, ~(4'b0001 << idx)});
      check_eq({tag, "_seg"}, {24'd0, seg}, {24'd0, exp_seg(v, m, idx)});
    end
  endtask

  task automatic check_now(input string tag, input int raw, input bit m);
    int idx;
    idx = an_index(an);
    if (idx < 0) idx = 0;
    check_eq(tag, {24'd0, seg}, {24'd0, exp_seg(clamp(raw), m, idx)});
  endtask

  initial begin
    int n, g, t, tprev, raw;
    bit m;
    int dir_vals [10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

    reset = 1'b1; humidity = 14'd0; temperature = 14'd2345; auto_en = 1'b0; mode_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_seg", {24'd0, seg}, 32'hFF);
    check_eq("rst_an", {28'd0, an}, 32'hF);
    check_eq("rst_busy", {31'd0, conv_busy}, 32'd0);
    reset = 1'b0;

    wait_busy(1'b1, 20, "t1_rise", n);
    wait_busy(1'b0, 30, "t1_fall", n);
    check_eq("t1_busy_len", n, 15);
    repeat (2) @(negedge clk);
    check_display("t1", 2345, 1'b0);

    humidity = 14'd45; mode_sel = 1'b1;
    repeat (40) @(negedge clk);
    check_display("t2a", 45, 1'b1);
    humidity = 14'd0;
    repeat (40) @(negedge clk);
    check_display("t2b", 0, 1'b1);

    mode_sel = 1'b0; temperature = 14'd12000;
    repeat (40) @(negedge clk);
    check_display("t3", 12000, 1'b0);

    temperature = 14'd2345;
    wait_busy(1'b1, 10, "t5_rise", n);
    repeat (4) @(negedge clk);
    temperature = 14'd1111;
    wait_busy(1'b0, 20, "t5_fall", n);
    check_eq("t5_first_len", n + 4, 15);
    wait_busy(1'b1, 10, "t5_restart", g);
    check_eq("t5_gap_ok", {31'd0, (g >= 1 && g <= 2)}, 32'd1);
    check_now("t5_old_value", 2345, 1'b0);
    wait_busy(1'b0, 20, "t5_fall2", n);
    repeat (2) @(negedge clk);
    check_display("t5", 1111, 1'b0);

    temperature = 14'd4321;
    wait_busy(1'b1, 10, "t6_rise", n);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_seg", {24'd0, seg}, 32'hFF);
    check_eq("t6_an", {28'd0, an}, 32'hF);
    check_eq("t6_busy", {31'd0, conv_busy}, 32'd0);
    reset = 1'b0;
    wait_busy(1'b1, 20, "t6_rise2", n);
    wait_busy(1'b0, 30, "t6_fall", n);
    check_eq("t6_busy_len", n, 15);
    repeat (2) @(negedge clk);
    check_display("t6", 4321, 1'b0);

    temperature = 14'd2500; humidity = 14'd60;
    repeat (40) @(negedge clk);
    check_display("t4_pre", 2500, 1'b0);
    auto_en = 1'b1;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_busy(1'b1, 80, "t4_flip", n);
      t = cyc;
      if (k > 0) check_eq("t4_period", t - tprev, 40);
      tprev = t;
      wait_busy(1'b0, 30, "t4_fall", n);
      repeat (2) @(negedge clk);
      m = (k % 2 == 0);
      check_now("t4_seg", m ? 60 : 2500, m);
    end

    auto_en = 1'b0;
    for (int r = 0; r < 14; r++) begin
      raw = (r < 10) ? dir_vals[r] : int'($urandom_range(0, 16383));
      m = $urandom_range(0, 1) == 1;
      mode_sel = m;
      if (m) begin
        humidity = 14'(raw); temperature = 14'($urandom_range(0, 16383));
      end else begin
        temperature = 14'(raw); humidity = 14'($urandom_range(0, 16383));
      end
      repeat (45) @(negedge clk);
      check_display("rnd", raw, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
